main_bus_controller: RTL and testbench

MAIN_BUS_CONTROLLER -- requirements
Module: main_bus_controller

---
 rtl/main_bus_pkg.sv | 28 ++
 rtl/main_bus_if.sv | 40 ++++
 rtl/main_bus_regfile.sv | 48 ++++
 rtl/main_bus_controller.sv | 145 ++++++++++++++
 tb/tb_main_bus_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_bus_pkg.sv
// rtl/main_bus_pkg.sv - bus source/destination encodings and controller state enum
package main_bus_pkg;

  localparam logic [3:0] ASSERT_NONE  = 4'd0;
  localparam logic [3:0] ASSERT_REGA  = 4'd1;
  localparam logic [3:0] ASSERT_REGB  = 4'd2;
  localparam logic [3:0] ASSERT_REGC  = 4'd3;
  localparam logic [3:0] ASSERT_REGD  = 4'd4;
  localparam logic [3:0] ASSERT_CONST = 4'd5;
  localparam logic [3:0] ASSERT_MEM   = 4'd6;
  localparam logic [3:0] ASSERT_ALU   = 4'd7;

  localparam logic [3:0] LOAD_NONE    = 4'd0;
  localparam logic [3:0] LOAD_REGA    = 4'd1;
  localparam logic [3:0] LOAD_REGB    = 4'd2;
  localparam logic [3:0] LOAD_REGC    = 4'd3;
  localparam logic [3:0] LOAD_REGD    = 4'd4;
  localparam logic [3:0] LOAD_ALU_LHS = 4'd5;
  localparam logic [3:0] LOAD_ALU_RHS = 4'd6;
  localparam logic [3:0] LOAD_MEMW    = 4'd7;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/main_bus_if.sv
// rtl/main_bus_if.sv - control word, memory handshake and register view of the main bus controller
interface main_bus_if;

  logic [3:0] MainAssert;
  logic [3:0] MainLoad;
  logic       BusRequest;
  logic       Break;
  logic       Continue;
  logic [7:0] ConstIn;
  logic [7:0] AluIn;
  logic [7:0] MemDataIn;
  logic       MemReady;
  logic [7:0] MainBus;
  logic [7:0] RegA;
  logic [7:0] RegB;
  logic [7:0] RegC;
  logic [7:0] RegD;
  logic [7:0] AluLhs;
  logic [7:0] AluRhs;
  logic       MemReq;
  logic       MemWrite;
  logic [7:0] MemDataOut;
  logic       Stall;
  logic       Halted;

  modport master (
    output MainAssert, MainLoad, BusRequest, Break, Continue,
    output ConstIn, AluIn, MemDataIn, MemReady,
    input  MainBus, RegA, RegB, RegC, RegD, AluLhs, AluRhs,
    input  MemReq, MemWrite, MemDataOut, Stall, Halted
  );

  modport slave (
    input  MainAssert, MainLoad, BusRequest, Break, Continue,
    input  ConstIn, AluIn, MemDataIn, MemReady,
    output MainBus, RegA, RegB, RegC, RegD, AluLhs, AluRhs,
    output MemReq, MemWrite, MemDataOut, Stall, Halted
  );

endinterface

// File: rtl/main_bus_regfile.sv
// rtl/main_bus_regfile.sv - general registers and ALU operand latches written from the main bus
module main_bus_regfile
  import main_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_sel,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_rega,
  output logic [7:0] o_regb,
  output logic [7:0] o_regc,
  output logic [7:0] o_regd,
  output logic [7:0] o_alu_lhs,
  output logic [7:0] o_alu_rhs
);

  logic [7:0] r_rega, r_regb, r_regc, r_regd, r_alu_lhs, r_alu_rhs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rega    <= 8'h00;
      r_regb    <= 8'h00;
      r_regc    <= 8'h00;
      r_regd    <= 8'h00;
      r_alu_lhs <= 8'h00;
      r_alu_rhs <= 8'h00;
    end else if (i_wr_en) begin
      case (i_wr_sel)
        LOAD_REGA:    r_rega    <= i_wr_data;
        LOAD_REGB:    r_regb    <= i_wr_data;
        LOAD_REGC:    r_regc    <= i_wr_data;
        LOAD_REGD:    r_regd    <= i_wr_data;
        LOAD_ALU_LHS: r_alu_lhs <= i_wr_data;
        LOAD_ALU_RHS: r_alu_rhs <= i_wr_data;
        default: ;
      endcase
    end
  end

  assign o_rega    = r_rega;
  assign o_regb    = r_regb;
  assign o_regc    = r_regc;
  assign o_regd    = r_regd;
  assign o_alu_lhs = r_alu_lhs;
  assign o_alu_rhs = r_alu_rhs;

endmodule

// File: rtl/main_bus_controller.sv
// rtl/main_bus_controller.sv - main bus source mux, load commit and memory/break sequencing
module main_bus_controller
  import main_bus_pkg::*;
(
  input  logic       ClockIn,
  input  logic       ResetIn_n,
  main_bus_if.slave  bus
);

  state_t     r_state;
  logic [3:0] r_cap_assert;
  logic [3:0] r_cap_load;
  logic       r_cap_break;
  logic [7:0] r_cap_bus;
  logic       r_mem_req;
  logic       r_mem_write;
  logic [7:0] r_mem_data_out;
  logic       r_stall;
  logic       r_halted;

  logic [7:0] w_bus;
  logic       w_wr_en;
  logic [3:0] w_wr_sel;
  logic [7:0] w_wr_data;
  logic [7:0] w_rega, w_regb, w_regc, w_regd, w_alu_lhs, w_alu_rhs;

  always_comb begin
    w_bus = 8'h00;
    case (bus.MainAssert)
      ASSERT_REGA:  w_bus = w_rega;
      ASSERT_REGB:  w_bus = w_regb;
      ASSERT_REGC:  w_bus = w_regc;
      ASSERT_REGD:  w_bus = w_regd;
      ASSERT_CONST: w_bus = bus.ConstIn;
      ASSERT_MEM:   w_bus = bus.MemDataIn;
      ASSERT_ALU:   w_bus = bus.AluIn;
      default:      w_bus = 8'h00;
    endcase
  end

  // A completed read whose source was not memory commits the bus value seen at capture time.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_sel  = LOAD_NONE;
    w_wr_data = 8'h00;
    if (r_state == ST_RUN && !bus.BusRequest) begin
      w_wr_en   = 1'b1;
      w_wr_sel  = bus.MainLoad;
      w_wr_data = w_bus;
    end else if (r_state == ST_MEMWAIT && bus.MemReady && r_cap_load != LOAD_MEMW) begin
      w_wr_en   = 1'b1;
      w_wr_sel  = r_cap_load;
      w_wr_data = (r_cap_assert == ASSERT_MEM) ? bus.MemDataIn : r_cap_bus;
    end
  end

  main_bus_regfile u_regfile (
    .i_clk     (ClockIn),
    .i_rst_n   (ResetIn_n),
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (w_wr_sel),
    .i_wr_data (w_wr_data),
    .o_rega    (w_rega),
    .o_regb    (w_regb),
    .o_regc    (w_regc),
    .o_regd    (w_regd),
    .o_alu_lhs (w_alu_lhs),
    .o_alu_rhs (w_alu_rhs)
  );

  always_ff @(posedge ClockIn or negedge ResetIn_n) begin
    if (!ResetIn_n) begin
      r_state        <= ST_RUN;
      r_cap_assert   <= ASSERT_NONE;
      r_cap_load     <= LOAD_NONE;
      r_cap_break    <= 1'b0;
      r_cap_bus      <= 8'h00;
      r_mem_req      <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_data_out <= 8'h00;
      r_stall        <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.BusRequest) begin
            r_state      <= ST_MEMWAIT;
            r_cap_assert <= bus.MainAssert;
            r_cap_load   <= bus.MainLoad;
            r_cap_break  <= bus.Break;
            r_cap_bus    <= w_bus;
            r_mem_req    <= 1'b1;
            r_mem_write  <= (bus.MainLoad == LOAD_MEMW);
            r_stall      <= 1'b1;
            if (bus.MainLoad == LOAD_MEMW)
              r_mem_data_out <= w_bus;
          end else if (bus.Break) begin
            r_state  <= ST_HALT;
            r_stall  <= 1'b1;
            r_halted <= 1'b1;
          end
        end
        ST_MEMWAIT: begin
          if (bus.MemReady) begin
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_cap_break) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_stall <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          if (bus.Continue) begin
            r_state  <= ST_RUN;
            r_stall  <= 1'b0;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_stall  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MainBus    = w_bus;
  assign bus.RegA       = w_rega;
  assign bus.RegB       = w_regb;
  assign bus.RegC       = w_regc;
  assign bus.RegD       = w_regd;
  assign bus.AluLhs     = w_alu_lhs;
  assign bus.AluRhs     = w_alu_rhs;
  assign bus.MemReq     = r_mem_req;
  assign bus.MemWrite   = r_mem_write;
  assign bus.MemDataOut = r_mem_data_out;
  assign bus.Stall      = r_stall;
  assign bus.Halted     = r_halted;

endmodule

// File: tb/tb_main_bus_controller.sv
// tb/tb_main_bus_controller.sv - directed bench with a transaction-level reference model for main_bus_controller
module tb_main_bus_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  main_bus_if u_if ();

  main_bus_controller dut (
    .ClockIn   (clk),
    .ResetIn_n (rst_n),
    .bus       (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index 0..5 = RegA, RegB, RegC, RegD, AluLhs, AluRhs
  logic [7:0] m_reg [0:5];
  bit         m_pending;
  bit         m_halted;
  logic [3:0] m_p_assert;
  logic [3:0] m_p_load;
  bit         m_p_break;
  logic [7:0] m_p_bus;
  logic [7:0] m_mdo;

  function automatic logic [7:0] bus_model(input logic [3:0] a);
    if (a >= 4'd1 && a <= 4'd4) return m_reg[a - 4'd1];
    if (a == 4'd5) return u_if.ConstIn;
    if (a == 4'd6) return u_if.MemDataIn;
    if (a == 4'd7) return u_if.AluIn;
    return 8'h00;
  endfunction

  function automatic void model_load(input logic [3:0] dst, input logic [7:0] val);
    if (dst >= 4'd1 && dst <= 4'd6) m_reg[dst - 4'd1] = val;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
      m_pending = 0;
      m_halted  = 0;
      m_p_assert = 4'd0;
      m_p_load   = 4'd0;
      m_p_break  = 0;
      m_p_bus    = 8'h00;
      m_mdo      = 8'h00;
    end else if (m_halted) begin
      if (u_if.Continue) m_halted = 0;
    end else if (m_pending) begin
      if (u_if.MemReady) begin
        if (m_p_load != 4'd7)
          model_load(m_p_load, (m_p_assert == 4'd6) ? u_if.MemDataIn : m_p_bus);
        m_pending = 0;
        m_halted  = m_p_break;
      end
    end else if (u_if.BusRequest) begin
      m_pending  = 1;
      m_p_assert = u_if.MainAssert;
      m_p_load   = u_if.MainLoad;
      m_p_break  = u_if.Break;
      m_p_bus    = bus_model(u_if.MainAssert);
      if (u_if.MainLoad == 4'd7) m_mdo = m_p_bus;
    end else begin
      model_load(u_if.MainLoad, bus_model(u_if.MainAssert));
      if (u_if.Break) m_halted = 1;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_bus",    u_if.MainBus,    bus_model(u_if.MainAssert));
      chk("cmp_rega",   u_if.RegA,       m_reg[0]);
      chk("cmp_regb",   u_if.RegB,       m_reg[1]);
      chk("cmp_regc",   u_if.RegC,       m_reg[2]);
      chk("cmp_regd",   u_if.RegD,       m_reg[3]);
      chk("cmp_lhs",    u_if.AluLhs,     m_reg[4]);
      chk("cmp_rhs",    u_if.AluRhs,     m_reg[5]);
      chk("cmp_memreq", {7'd0, u_if.MemReq},   {7'd0, m_pending});
      chk("cmp_memwr",  {7'd0, u_if.MemWrite}, {7'd0, m_pending && m_p_load == 4'd7});
      chk("cmp_mdo",    u_if.MemDataOut, m_mdo);
      chk("cmp_stall",  {7'd0, u_if.Stall},    {7'd0, m_pending || m_halted});
      chk("cmp_halted", {7'd0, u_if.Halted},   {7'd0, m_halted});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.MainAssert = 4'd0;
    u_if.MainLoad   = 4'd0;
    u_if.BusRequest = 1'b0;
    u_if.Break      = 1'b0;
    u_if.Continue   = 1'b0;
    u_if.MemReady   = 1'b0;
  endtask

  task automatic word(input logic [3:0] a, input logic [3:0] l, input logic br);
    u_if.MainAssert = a;
    u_if.MainLoad   = l;
    u_if.BusRequest = br;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    u_if.ConstIn   = 8'h00;
    u_if.AluIn     = 8'h00;
    u_if.MemDataIn = 8'h00;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_rega", u_if.RegA, 8'h00);
    chk("rst_stall", {7'd0, u_if.Stall}, 8'h00);
    chk("rst_memreq", {7'd0, u_if.MemReq}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Const to RegB
    u_if.ConstIn = 8'h3C;
    word(4'd5, 4'd2, 1'b0);
    #1 chk("lit_bus_const", u_if.MainBus, 8'h3C);
    tick();
    chk("lit_regb", u_if.RegB, 8'h3C);
    word(4'd5, 4'd1, 1'b0);
    tick();
    word(4'd1, 4'd5, 1'b0);
    tick();
    chk("lit_alulhs", u_if.AluLhs, 8'h3C);
    chk("lit_rega_kept", u_if.RegA, 8'h3C);

    // ALU result to AluRhs, MemReady ignored in RUN, reserved assert/load
    u_if.AluIn = 8'hC3;
    u_if.MemReady = 1'b1;
    word(4'd7, 4'd6, 1'b0);
    tick();
    u_if.MemReady = 1'b0;
    chk("lit_alurhs", u_if.AluRhs, 8'hC3);
    word(4'd9, 4'd1, 1'b0);
    tick();
    chk("lit_reserved_assert", u_if.RegA, 8'h00);
    word(4'd5, 4'd12, 1'b0);
    tick();

    // Memory read into RegC, ready on the third wait cycle
    word(4'd6, 4'd3, 1'b1);
    tick();
    idle();
    chk("lit_rd_memreq", {7'd0, u_if.MemReq}, 8'h01);
    chk("lit_rd_stall", {7'd0, u_if.Stall}, 8'h01);
    tick();
    tick();
    u_if.MemReady  = 1'b1;
    u_if.MemDataIn = 8'hA5;
    tick();
    idle();
    chk("lit_regc", u_if.RegC, 8'hA5);
    chk("lit_rd_stall_clr", {7'd0, u_if.Stall}, 8'h00);

    // RegD to memory write
    u_if.ConstIn = 8'h77;
    word(4'd5, 4'd4, 1'b0);
    tick();
    word(4'd4, 4'd7, 1'b1);
    tick();
    idle();
    chk("lit_wr_memwrite", {7'd0, u_if.MemWrite}, 8'h01);
    chk("lit_wr_mdo", u_if.MemDataOut, 8'h77);
    u_if.Continue = 1'b1;
    tick();
    tick();
    u_if.Continue = 1'b0;
    u_if.MemReady = 1'b1;
    tick();
    idle();
    chk("lit_wr_done", {7'd0, u_if.MemReq}, 8'h00);

    // Break with load, halted loads ignored, resume
    u_if.ConstIn = 8'h11;
    word(4'd5, 4'd1, 1'b0);
    u_if.Break = 1'b1;
    tick();
    idle();
    chk("lit_brk_rega", u_if.RegA, 8'h11);
    chk("lit_brk_halted", {7'd0, u_if.Halted}, 8'h01);
    u_if.ConstIn = 8'h99;
    word(4'd5, 4'd2, 1'b1);
    tick();
    tick();
    chk("lit_halt_regb", u_if.RegB, 8'h3C);
    chk("lit_halt_memreq", {7'd0, u_if.MemReq}, 8'h00);
    idle();
    u_if.Continue = 1'b1;
    tick();
    idle();
    chk("lit_resume", {7'd0, u_if.Halted}, 8'h00);
    u_if.Break = 1'b1;
    u_if.Continue = 1'b1;
    tick();
    idle();
    chk("lit_brk_cont", {7'd0, u_if.Halted}, 8'h01);
    u_if.Continue = 1'b1;
    tick();
    idle();

    // Break captured with a memory read
    word(4'd6, 4'd4, 1'b1);
    u_if.Break = 1'b1;
    tick();
    idle();
    u_if.MemReady  = 1'b1;
    u_if.MemDataIn = 8'h5A;
    tick();
    idle();
    chk("lit_memrd_brk_regd", u_if.RegD, 8'h5A);
    chk("lit_memrd_brk_halt", {7'd0, u_if.Halted}, 8'h01);
    u_if.Continue = 1'b1;
    tick();
    idle();

    // Reset in the middle of a pending write
    word(4'd1, 4'd7, 1'b1);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_memreq", {7'd0, u_if.MemReq}, 8'h00);
    chk("lit_rst_stall", {7'd0, u_if.Stall}, 8'h00);
    chk("lit_rst_rega", u_if.RegA, 8'h00);
    chk("lit_rst_regc", u_if.RegC, 8'h00);
    chk("lit_rst_regd", u_if.RegD, 8'h00);
    chk("lit_rst_mdo", u_if.MemDataOut, 8'h00);
    tick();
    rst_n = 1'b1;
    u_if.MemReady = 1'b1;
    tick();
    idle();
    tick();
    chk("lit_post_rst_memreq", {7'd0, u_if.MemReq}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
